// File: rtl/gps_sample_packer_pkg.sv
// Shared definitions for the GPS sample bridge: nibble bit order,
// default FIFO depth and the packer state encoding.
`timescale 1ns/1ps
package gps_bridge_pkg;

    // Bit positions of each sample bit inside a packed nibble
    localparam int NIB_I1 = 3;
    localparam int NIB_I0 = 2;
    localparam int NIB_Q1 = 1;
    localparam int NIB_Q0 = 0;

    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    function automatic logic [3:0] make_nibble(input logic i1, input logic i0,
                                               input logic q1, input logic q0);
        logic [3:0] n;
        n         = '0;
        n[NIB_I1] = i1;
        n[NIB_I0] = i0;
        n[NIB_Q1] = q1;
        n[NIB_Q0] = q0;
        return n;
    endfunction

endpackage

// File: rtl/gps_sample_packer_if.sv
// Sample input, byte stream output and status signals of the packer.
// The master side is the environment, the slave side is the packer.
`timescale 1ns/1ps
interface gps_sample_packer_if #(
    parameter int FIFO_DEPTH = gps_bridge_pkg::DEFAULT_FIFO_DEPTH
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             DATAREADY;
    logic             GPS_I0;
    logic             GPS_I1;
    logic             GPS_Q0;
    logic             GPS_Q1;
    logic [7:0]       BYTE_DATA;
    logic             BYTE_VALID;
    logic             BYTE_READY;
    logic             OVERFLOW;
    logic             CLEAR_OVF;
    logic [LVL_W-1:0] FILL_LEVEL;

    modport master (
        output DATAREADY, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, BYTE_READY, CLEAR_OVF,
        input  BYTE_DATA, BYTE_VALID, OVERFLOW, FILL_LEVEL
    );

    modport slave (
        input  DATAREADY, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, BYTE_READY, CLEAR_OVF,
        output BYTE_DATA, BYTE_VALID, OVERFLOW, FILL_LEVEL
    );

endinterface

// File: rtl/gps_sample_packer_byte_fifo.sv
// Show-ahead byte FIFO. A push while full is only taken when a pop
// frees a slot in the same cycle; otherwise the caller sees o_full.
`timescale 1ns/1ps
module byte_fifo
    import gps_bridge_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; o_empty masks stale contents
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/gps_sample_packer.sv
// Packs pairs of 4-bit GPS samples into bytes and queues them for an
// SPI serializer. A byte that finds the FIFO full is dropped and
// flagged in the sticky OVERFLOW bit.
`timescale 1ns/1ps
module gps_sample_packer
    import gps_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                MCU_CLK_25_000,
    input  logic                RESET_N,
    gps_sample_packer_if.slave  bus
);
    pack_state_t r_state;
    pack_state_t w_state_nxt;
    logic [3:0]  r_nibble;
    logic [3:0]  w_nibble_nxt;
    logic [3:0]  w_cur;
    logic [7:0]  w_byte;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_drop;
    logic        r_ovf;

    assign w_cur          = make_nibble(bus.GPS_I1, bus.GPS_I0, bus.GPS_Q1, bus.GPS_Q0);
    assign w_byte         = {r_nibble, w_cur};
    assign w_pop          = ~w_empty & bus.BYTE_READY;
    assign w_drop         = w_push & w_full & ~w_pop;
    assign bus.BYTE_VALID = ~w_empty;
    assign bus.OVERFLOW   = r_ovf;

    // Packer state and held upper nibble
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= EMPTY;
            r_nibble <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_nibble <= w_nibble_nxt;
        end
    end

    // Next-state: first strobe holds the nibble, second completes and pushes the byte
    always_comb begin
        w_state_nxt  = r_state;
        w_nibble_nxt = r_nibble;
        w_push       = 1'b0;
        if (bus.DATAREADY) begin
            case (r_state)
                EMPTY: begin
                    w_nibble_nxt = w_cur;
                    w_state_nxt  = HALF;
                end
                HALF: begin
                    w_push      = 1'b1;
                    w_state_nxt = EMPTY;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
        if (!RESET_N)          r_ovf <= 1'b0;
        else if (w_drop)       r_ovf <= 1'b1;
        else if (bus.CLEAR_OVF) r_ovf <= 1'b0;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (MCU_CLK_25_000),
        .i_rst_n (RESET_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_byte),
        .o_data  (bus.BYTE_DATA),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (bus.FILL_LEVEL)
    );

endmodule

// File: tb/tb_gps_sample_packer.sv
// Directed bench for gps_sample_packer with a scoreboard queue of
// expected output bytes checked by an independent monitor.
`timescale 1ns/1ps
module tb_gps_sample_packer;
    import gps_bridge_pkg::*;

    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    gps_sample_packer_if #(.FIFO_DEPTH(DEPTH)) bus();

    gps_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .MCU_CLK_25_000 (clk),
        .RESET_N        (rst_n),
        .bus            (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One DATAREADY strobe; sample bits are inverted afterwards so any
    // sampling without DATAREADY would corrupt the output
    task automatic strobe(input logic [3:0] n, input logic clr = 1'b0);
        bus.DATAREADY = 1'b1;
        bus.GPS_I1    = n[3];
        bus.GPS_I0    = n[2];
        bus.GPS_Q1    = n[1];
        bus.GPS_Q0    = n[0];
        bus.CLEAR_OVF = clr;
        @(posedge clk);
        #1;
        bus.DATAREADY = 1'b0;
        bus.CLEAR_OVF = 1'b0;
        bus.GPS_I1    = ~n[3];
        bus.GPS_I0    = ~n[2];
        bus.GPS_Q1    = ~n[1];
        bus.GPS_Q0    = ~n[0];
    endtask

    // Monitor: every accepted byte is compared with the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.BYTE_VALID === 1'b1 && bus.BYTE_READY === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_byte: got 0x%0h, expected none at %0t", bus.BYTE_DATA, $time);
            end else begin
                chk("byte_out", {24'h0, bus.BYTE_DATA}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [3:0] nb;
        logic [3:0] prev;
        logic [3:0] hi;
        logic [3:0] lo;

        bus.DATAREADY  = 1'b0;
        bus.GPS_I0     = 1'b0;
        bus.GPS_I1     = 1'b0;
        bus.GPS_Q0     = 1'b0;
        bus.GPS_Q1     = 1'b0;
        bus.BYTE_READY = 1'b0;
        bus.CLEAR_OVF  = 1'b0;
        prev           = '0;

        // Reset state
        cyc(2);
        chk("rst_valid", {31'h0, bus.BYTE_VALID}, 0);
        chk("rst_fill",  {27'h0, bus.FILL_LEVEL}, 0);
        chk("rst_ovf",   {31'h0, bus.OVERFLOW},   0);
        rst_n = 1'b1;
        cyc(1);

        // 0xA then 0x5 with an idle gap between -> 0xA5
        strobe(4'hA);
        cyc(3);
        strobe(4'h5);
        exp_q.push_back(8'hA5);
        chk("a5_valid", {31'h0, bus.BYTE_VALID}, 1);
        chk("a5_data",  {24'h0, bus.BYTE_DATA},  32'hA5);
        chk("a5_fill",  {27'h0, bus.FILL_LEVEL}, 1);
        bus.BYTE_READY = 1'b1;
        cyc(1);
        bus.BYTE_READY = 1'b0;
        chk("a5_drained_valid", {31'h0, bus.BYTE_VALID}, 0);
        chk("a5_drained_fill",  {27'h0, bus.FILL_LEVEL}, 0);

        // 34 strobes 0..F repeating: 16 bytes stored, 17th dropped
        // while CLEAR_OVF is asserted in the same cycle
        for (int j = 0; j < 2 * DEPTH + 2; j++) begin
            nb = 4'(j);
            strobe(nb, (j == 2 * DEPTH + 1));
            if (j % 2 == 1 && j / 2 < DEPTH) exp_q.push_back({prev, nb});
            if (j == 2 * DEPTH - 1) begin
                chk("full_fill", {27'h0, bus.FILL_LEVEL}, 16);
                chk("full_ovf",  {31'h0, bus.OVERFLOW},   0);
            end
            prev = nb;
        end
        chk("drop_ovf_set_wins", {31'h0, bus.OVERFLOW},   1);
        chk("drop_fill",         {27'h0, bus.FILL_LEVEL}, 16);
        chk("drop_head",         {24'h0, bus.BYTE_DATA},  32'h01);
        bus.CLEAR_OVF = 1'b1;
        cyc(1);
        bus.CLEAR_OVF = 1'b0;
        chk("clear_ovf", {31'h0, bus.OVERFLOW}, 0);

        // Full FIFO: push 0x23 and pop 0x01 in the same cycle
        strobe(4'h2);
        bus.BYTE_READY = 1'b1;
        strobe(4'h3);
        bus.BYTE_READY = 1'b0;
        exp_q.push_back(8'h23);
        chk("pushpop_ovf",  {31'h0, bus.OVERFLOW},   0);
        chk("pushpop_fill", {27'h0, bus.FILL_LEVEL}, 16);
        chk("pushpop_head", {24'h0, bus.BYTE_DATA},  32'h23);

        // Plain drop when full, then clear and drain everything
        strobe(4'h4);
        strobe(4'h4);
        chk("drop2_ovf",  {31'h0, bus.OVERFLOW},   1);
        chk("drop2_fill", {27'h0, bus.FILL_LEVEL}, 16);
        bus.CLEAR_OVF = 1'b1;
        cyc(1);
        bus.CLEAR_OVF = 1'b0;
        chk("drop2_clear", {31'h0, bus.OVERFLOW}, 0);
        bus.BYTE_READY = 1'b1;
        cyc(DEPTH);
        bus.BYTE_READY = 1'b0;
        chk("drain_fill",  {27'h0, bus.FILL_LEVEL}, 0);
        chk("drain_valid", {31'h0, bus.BYTE_VALID}, 0);
        chk("drain_queue", exp_q.size(), 0);

        // Reset with a stored byte and a held nibble discards both;
        // the strobe on the first edge after release is taken
        strobe(4'h7);
        strobe(4'h7);
        strobe(4'h3);
        chk("pre_rst_fill", {27'h0, bus.FILL_LEVEL}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, bus.BYTE_VALID}, 0);
        chk("async_rst_fill",  {27'h0, bus.FILL_LEVEL}, 0);
        cyc(2);
        rst_n = 1'b1;
        strobe(4'hC);
        strobe(4'h1);
        exp_q.push_back(8'hC1);
        chk("post_rst_valid", {31'h0, bus.BYTE_VALID}, 1);
        chk("post_rst_data",  {24'h0, bus.BYTE_DATA},  32'hC1);
        chk("post_rst_fill",  {27'h0, bus.FILL_LEVEL}, 1);
        bus.BYTE_READY = 1'b1;
        cyc(1);

        // Streaming: 40 bytes, one strobe every 6 cycles, consumer always ready
        for (int b = 0; b < 40; b++) begin
            hi = 4'(b * 3);
            lo = 4'(b * 5 + 1);
            strobe(hi);
            cyc(5);
            strobe(lo);
            exp_q.push_back({hi, lo});
            cyc(5);
        end
        cyc(2);
        bus.BYTE_READY = 1'b0;
        chk("stream_ovf",   {31'h0, bus.OVERFLOW},   0);
        chk("stream_fill",  {27'h0, bus.FILL_LEVEL}, 0);
        chk("stream_queue", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gps_sample_packer.md
GPS_SAMPLE_PACKER -- requirements
Module: gps_sample_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, giving the number of byte entries; it must be a power of two and at least 4.
REQ-002 The block SHALL have port MCU_CLK_25_000  in  1  sole clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port DATAREADY  in  1  single-cycle strobe meaning a new GPS sample is valid this cycle.
REQ-005 The block SHALL have ports GPS_I0, GPS_I1, GPS_Q0, GPS_Q1  in  1 each  synchronized sample bits, sampled only when DATAREADY=1.
REQ-006 The block SHALL have port BYTE_DATA  out  8  head-of-FIFO byte toward the SPI serializer.
REQ-007 The block SHALL have port BYTE_VALID  out  1  high whenever the FIFO is non-empty.
REQ-008 The block SHALL have port BYTE_READY  in  1  consumer accepts BYTE_DATA when BYTE_VALID=1 and BYTE_READY=1.
REQ-009 The block SHALL have port OVERFLOW  out  1  sticky flag meaning at least one packed byte was dropped.
REQ-010 The block SHALL have port CLEAR_OVF  in  1  synchronous clear for OVERFLOW.
REQ-011 The block SHALL have port FILL_LEVEL  out  clog2(FIFO_DEPTH)+1  current number of stored bytes.

Function
REQ-012 Each sample SHALL form a nibble {GPS_I1,GPS_I0,GPS_Q1,GPS_Q0}, with bit 3 = GPS_I1.
REQ-013 The packer SHALL be a two-state machine: EMPTY (no nibble held) and HALF (upper nibble held).
REQ-014 On DATAREADY in EMPTY, the nibble SHALL be latched as byte bits [7:4] and the state SHALL go to HALF.
REQ-015 On DATAREADY in HALF, {held nibble, current nibble} SHALL be pushed into the FIFO in that same cycle, and the state SHALL return to EMPTY.
REQ-016 Without DATAREADY, the state and the held nibble SHALL be unchanged.
REQ-017 The FIFO SHALL be show-ahead: BYTE_DATA equals the oldest entry whenever BYTE_VALID=1, and is don't-care otherwise.
REQ-018 Latency: BYTE_VALID SHALL rise on the cycle after a push into an empty FIFO.
REQ-019 A pop SHALL occur when BYTE_VALID and BYTE_READY are both 1; the next entry, if any, appears on the following cycle.
REQ-020 A push SHALL be accepted when FILL_LEVEL<FIFO_DEPTH, or when FILL_LEVEL=FIFO_DEPTH and a pop occurs in the same cycle (FILL_LEVEL unchanged).
REQ-021 A push when full without a simultaneous pop SHALL drop the byte, set OVERFLOW, leave FIFO contents untouched, and still return the packer to EMPTY.
REQ-022 Simultaneous push and pop when non-full SHALL leave FILL_LEVEL unchanged.
REQ-023 Read and write pointers SHALL be clog2(FIFO_DEPTH) bits wide and SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-024 BYTE_READY while BYTE_VALID=0 SHALL have no effect.
REQ-025 OVERFLOW SHALL clear on CLEAR_OVF=1; when a drop and CLEAR_OVF coincide, OVERFLOW SHALL be 1 (set wins).
REQ-026 FILL_LEVEL SHALL be registered and accurate on the cycle after each push or pop.

Reset
REQ-027 RESET_N=0 SHALL immediately force: packer EMPTY, held nibble 0, pointers 0, FILL_LEVEL 0, BYTE_VALID 0, OVERFLOW 0.
REQ-028 Reset asserted mid-byte (HALF) or with a non-empty FIFO SHALL discard all held data, with no partial byte emitted after release.
REQ-029 The FIFO storage array need not be reset; this is safe because BYTE_VALID gates it.
REQ-030 A DATAREADY coinciding with the first clock edge after RESET_N deassertion SHALL be processed normally.

Structure
REQ-031 The shared package gps_bridge_pkg SHALL hold: the nibble bit-order constants, the default FIFO_DEPTH, and the packer state enumeration (EMPTY, HALF).
REQ-032 Storage and pointers SHALL live in one sub-module, byte_fifo (parameterized depth, push/pop/full/empty/level); the packer FSM and overflow logic stay in the top level.

Verification
REQ-033 Scenario: samples 0xA then 0x5 on DATAREADY, BYTE_READY=0 -> BYTE_VALID=1 one cycle after the second strobe, BYTE_DATA=0xA5, FILL_LEVEL=1.
REQ-034 Scenario: 2*FIFO_DEPTH+2 strobes (0x0..0xF repeating) with BYTE_READY=0 -> FILL_LEVEL=16, OVERFLOW=1 after the 17th byte push, head still 0x01.
REQ-035 Scenario: FIFO full, a push and a pop in the same cycle -> OVERFLOW stays 0, FILL_LEVEL stays 16, the new byte becomes the tail.
REQ-036 Scenario: one strobe (nibble 0x3), then RESET_N pulse, then strobes 0xC and 0x1 -> the first output byte is 0xC1.
REQ-037 Scenario: BYTE_READY held high while 40 bytes stream at one strobe every 6 cycles -> bytes are output in order, pointers wrap, OVERFLOW=0.
REQ-038 Scenario: CLEAR_OVF asserted in the same cycle as a drop -> OVERFLOW=1; CLEAR_OVF alone on the next cycle -> OVERFLOW=0.
